// File: rtl/uart_rx_param.sv
// UART receiver with 16x-style oversampling, 3-sample majority vote, configurable frame format,
// and a valid/ready holding register. Flags parity, framing, overrun and break conditions.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_break,
    output logic                 rx_busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int NW  = $clog2(DATA_BITS);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] S_M1      = SW'(M - 1);
    localparam logic [SW-1:0] S_M       = SW'(M);
    localparam logic [SW-1:0] S_VOTE    = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 2);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || DIV < 1) begin : g_bad_fmt
        $error("uart_rx_param: bad PARITY/STOP_BITS or baud too high");
    end

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q;
    logic                   rxm_q, rxs_q, rxs_prev_q;
    logic [1:0]             sync_fill_q;
    logic [DW-1:0]          div_q;
    logic [SW-1:0]          s_q;
    logic [1:0]             smp_q;
    logic [NW-1:0]          n_q;
    logic                   stop_n_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bit_q, par_err_acc_q, ferr_acc_q, stop0_acc_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q, perr_q, ferr_q, ovr_q, brk_q, busy_q;

    logic tick, vote, vote_t, bit_end, last_stop, accept;
    logic frame_err_d, break_d;

    assign tick        = (div_q == DIV_LAST);
    assign vote        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    assign vote_t      = tick && (s_q == S_VOTE);
    assign bit_end     = tick && (s_q == S_LAST);
    assign last_stop   = (state_q == STOP) && vote_t && (stop_n_q == STOP_LAST);
    assign accept      = valid_q && rx_ready;
    assign frame_err_d = ferr_acc_q | ~vote;
    // An all-zero frame, stop bits included, is a held-low line rather than a character.
    assign break_d     = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && stop0_acc_q && !vote;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HUNT;
            rxm_q         <= 1'b1;
            rxs_q         <= 1'b1;
            rxs_prev_q    <= 1'b1;
            sync_fill_q   <= '0;
            div_q         <= '0;
            s_q           <= '0;
            smp_q         <= '0;
            n_q           <= '0;
            stop_n_q      <= 1'b0;
            shift_q       <= '0;
            par_bit_q     <= 1'b0;
            par_err_acc_q <= 1'b0;
            ferr_acc_q    <= 1'b0;
            stop0_acc_q   <= 1'b1;
            data_q        <= '0;
            valid_q       <= 1'b0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            ovr_q         <= 1'b0;
            brk_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rxm_q       <= RxD;
            rxs_q       <= rxm_q;
            rxs_prev_q  <= rxs_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};

            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
                if (s_q == S_M1) smp_q[0] <= rxs_q;
                if (s_q == S_M)  smp_q[1] <= rxs_q;
            end

            ovr_q <= 1'b0;
            brk_q <= 1'b0;
            if (accept) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
            end

            case (state_q)
                // Sync flops come out of reset high, so only trust rxs once real samples fill them.
                HUNT: begin
                    if (sync_fill_q[1] && rxs_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (rxs_prev_q && !rxs_q) begin
                        state_q       <= START;
                        busy_q        <= 1'b1;
                        div_q         <= '0;
                        s_q           <= '0;
                        par_bit_q     <= 1'b0;
                        par_err_acc_q <= 1'b0;
                        ferr_acc_q    <= 1'b0;
                        stop0_acc_q   <= 1'b1;
                    end
                end
                START: begin
                    if (vote_t && vote) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= DATA;
                        n_q     <= '0;
                    end
                end
                DATA: begin
                    if (vote_t) shift_q[n_q] <= vote;
                    if (bit_end) begin
                        if (n_q == N_LAST) begin
                            state_q  <= (PARITY != 0) ? PAR : STOP;
                            stop_n_q <= 1'b0;
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (vote_t) begin
                        par_bit_q     <= vote;
                        par_err_acc_q <= ((^shift_q) ^ vote) != ODD_PAR;
                    end
                    if (bit_end) begin
                        state_q  <= STOP;
                        stop_n_q <= 1'b0;
                    end
                end
                STOP: begin
                    if (vote_t) begin
                        ferr_acc_q  <= frame_err_d;
                        stop0_acc_q <= stop0_acc_q & ~vote;
                    end
                    if (last_stop) begin
                        if (break_d) begin
                            brk_q   <= 1'b1;
                            state_q <= HUNT;
                            busy_q  <= 1'b1;
                        end else begin
                            // Leave mid-stop-bit so the next start edge is caught with half a bit to spare.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (!valid_q || rx_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                perr_q  <= par_err_acc_q;
                                ferr_q  <= frame_err_d;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end
                    end else if (bit_end) begin
                        stop_n_q <= stop_n_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= HUNT;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_overrun    = ovr_q;
    assign rx_break      = brk_q;
    assign rx_busy       = busy_q;

endmodule
